// File: rtl/forward_scoreboard.sv
// forward_scoreboard: in-flight result tracker between EX and the regfile write port.
// Keeps DEPTH result slots (slot 0 youngest, slot DEPTH-1 retiring), forwards the youngest
// matching result to each operand source, stalls on load-use hazards and holds the whole
// pipe while the retiring slot is a load still waiting for memory data.
module forward_scoreboard #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_we,
    input  logic                    issue_load,
    input  logic [XLEN-1:0]         ex_result,
    input  logic                    flush,
    input  logic                    mem_valid,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic [5*NUM_SRC-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]      src_used,
    output logic [NUM_SRC-1:0]      fwd_hit,
    output logic [XLEN*NUM_SRC-1:0] fwd_data,
    output logic                    stall,
    output logic [1:0]              stall_reason,
    output logic                    wb_valid,
    output logic [4:0]              wb_addr,
    output logic [XLEN-1:0]         wb_data,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int LAST = DEPTH - 1;

    // Slot state: valid/ready are control (reset), rd/data are payload (not reset).
    logic [DEPTH-1:0] slot_v;
    logic [DEPTH-1:0] slot_rdy;
    logic [4:0]       slot_rd   [DEPTH];
    logic [XLEN-1:0]  slot_data [DEPTH];

    // Slot view with this cycle's load fill already applied.
    logic [DEPTH-1:0] fill_sel;
    logic [DEPTH-1:0] eff_rdy;
    logic [XLEN-1:0]  eff_data [DEPTH];
    logic             fill_found;

    logic             hazard_any;
    logic             mem_hold;
    logic             advance;
    logic             accept;

    logic             m_found;
    logic             m_rdy;
    logic [XLEN-1:0]  m_data;
    logic [4:0]       cur_addr;

    // Pick the oldest pending load for the returning data and build the bypassed slot view.
    always_comb begin
        fill_sel   = '0;
        fill_found = 1'b0;
        for (int k = LAST; k >= 0; k--) begin
            if (!fill_found && slot_v[k] && !slot_rdy[k]) begin
                fill_sel[k] = mem_valid;
                fill_found  = 1'b1;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            eff_rdy[k]  = slot_rdy[k] | fill_sel[k];
            eff_data[k] = fill_sel[k] ? mem_rdata : slot_data[k];
        end
    end

    // Per-source lookup: scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_hit    = '0;
        fwd_data   = '0;
        hazard_any = 1'b0;
        m_found    = 1'b0;
        m_rdy      = 1'b0;
        m_data     = '0;
        cur_addr   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            m_found  = 1'b0;
            m_rdy    = 1'b0;
            m_data   = '0;
            cur_addr = src_addr[5*i +: 5];
            for (int j = LAST; j >= 0; j--) begin
                if (src_used[i] && (cur_addr != 5'd0) && slot_v[j] && (slot_rd[j] == cur_addr)) begin
                    m_found = 1'b1;
                    m_rdy   = eff_rdy[j];
                    m_data  = eff_data[j];
                end
            end
            if (m_found && m_rdy) begin
                fwd_hit[i]              = 1'b1;
                fwd_data[XLEN*i +: XLEN] = m_data;
            end else if (m_found) begin
                hazard_any = 1'b1;
            end
        end
    end

    // Pipe control and retirement; the pipe freezes only while the retiring load has no data.
    always_comb begin
        mem_hold     = slot_v[LAST] & ~slot_rdy[LAST] & ~mem_valid;
        advance      = ~mem_hold;
        stall        = hazard_any | mem_hold;
        stall_reason = {mem_hold, hazard_any};
        accept       = issue_valid & ~stall & ~flush;
        wb_valid     = advance & slot_v[LAST];
        wb_addr      = wb_valid ? slot_rd[LAST] : 5'd0;
        wb_data      = wb_valid ? eff_data[LAST] : '0;
    end

    // ---- slot pipeline: control ----
    // Shift valid/ready on advance (bubble in slot 0 unless accepted); otherwise only fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v   <= '0;
            slot_rdy <= '0;
        end else if (advance) begin
            for (int k = LAST; k >= 1; k--) begin
                slot_v[k]   <= slot_v[k-1];
                slot_rdy[k] <= eff_rdy[k-1];
            end
            slot_v[0]   <= accept & issue_we & (issue_rd != 5'd0);
            slot_rdy[0] <= ~issue_load;
        end else begin
            slot_rdy <= eff_rdy;
        end
    end

    // ---- slot pipeline: payload ----
    // Shift destination/data alongside the control bits; a held pipe still absorbs load data.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = LAST; k >= 1; k--) begin
                slot_rd[k]   <= slot_rd[k-1];
                slot_data[k] <= eff_data[k-1];
            end
            slot_rd[0]   <= issue_rd;
            slot_data[0] <= ex_result;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_data[k] <= eff_data[k];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard (DEPTH=3, NUM_SRC=2, 2-bit stall counter so that
// saturation is reachable). Inputs change on the falling edge; outputs are sampled 1 time
// unit later, well before the next rising edge.
module tb_forward_scoreboard;

    localparam int XLEN = 32;
    localparam int DEPTH = 3;
    localparam int NUM_SRC = 2;
    localparam int CNT_W = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    issue_valid;
    logic [4:0]              issue_rd;
    logic                    issue_we;
    logic                    issue_load;
    logic [XLEN-1:0]         ex_result;
    logic                    flush;
    logic                    mem_valid;
    logic [XLEN-1:0]         mem_rdata;
    logic [5*NUM_SRC-1:0]    src_addr;
    logic [NUM_SRC-1:0]      src_used;
    logic [NUM_SRC-1:0]      fwd_hit;
    logic [XLEN*NUM_SRC-1:0] fwd_data;
    logic                    stall;
    logic [1:0]              stall_reason;
    logic                    wb_valid;
    logic [4:0]              wb_addr;
    logic [XLEN-1:0]         wb_data;
    logic [CNT_W-1:0]        stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    forward_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
        .issue_load(issue_load), .ex_result(ex_result), .flush(flush),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .src_addr(src_addr), .src_used(src_used),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .stall(stall), .stall_reason(stall_reason),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        issue_valid = 1'b0; issue_rd = 5'd0; issue_we = 1'b0; issue_load = 1'b0;
        ex_result = '0; flush = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        src_addr = '0; src_used = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic load, input logic [XLEN-1:0] val);
        issue_valid = 1'b1; issue_rd = rd; issue_we = 1'b1; issue_load = load; ex_result = val;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk); set_idle();
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        src_used = 2'b11; src_addr = {5'd1, 5'd2};
        #1;
        vectors++; if ({stall, stall_reason} !== 3'b000) begin miscompares++; $display("FAIL reset_stall: got %b expected 000", {stall, stall_reason}); end
        vectors++; if (fwd_hit !== 2'b00 || fwd_data !== '0) begin miscompares++; $display("FAIL reset_fwd: got hit=%b data=%h expected 0", fwd_hit, fwd_data); end
        vectors++; if ({wb_valid, wb_addr, wb_data} !== '0) begin miscompares++; $display("FAIL reset_wb: got v=%b a=%0d d=%h expected 0", wb_valid, wb_addr, wb_data); end
        vectors++; if (stall_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_alu_chain();
        @(negedge clk); set_idle(); issue(5'd5, 1'b0, 32'h11);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL t1_issue_stall: got %b expected 0", stall); end
        @(negedge clk); set_idle(); src_used = 2'b11; src_addr = {5'd0, 5'd5};
        #1;
        vectors++; if (fwd_hit !== 2'b01) begin miscompares++; $display("FAIL t1_hit: got %b expected 01", fwd_hit); end
        vectors++; if (fwd_data !== {32'h0, 32'h11}) begin miscompares++; $display("FAIL t1_data: got %h expected 0000000000000011", fwd_data); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL t1_stall: got %b expected 0", stall); end
        @(negedge clk); set_idle();
        #1;
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL t1_early_wb: got %b expected 0", wb_valid); end
        @(negedge clk); set_idle();
        #1;
        vectors++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd5, 32'h11}) begin miscompares++; $display("FAIL t1_wb: got v=%b a=%0d d=%h expected 1/5/11", wb_valid, wb_addr, wb_data); end
        idle_cycles(3);
    endtask

    task automatic test_load_use();
        @(negedge clk); set_idle(); issue(5'd6, 1'b1, 32'hDEAD);
        @(negedge clk); set_idle(); src_used = 2'b01; src_addr = {5'd0, 5'd6};
        #1;
        vectors++; if ({stall, stall_reason} !== 3'b101) begin miscompares++; $display("FAIL t2_hazard: got %b expected 101", {stall, stall_reason}); end
        vectors++; if (fwd_hit !== 2'b00) begin miscompares++; $display("FAIL t2_nohit: got %b expected 00", fwd_hit); end
        @(negedge clk); set_idle(); src_used = 2'b01; src_addr = {5'd0, 5'd6};
        mem_valid = 1'b1; mem_rdata = 32'hAB;
        #1;
        vectors++; if ({stall, stall_reason} !== 3'b000) begin miscompares++; $display("FAIL t2_release: got %b expected 000", {stall, stall_reason}); end
        vectors++; if (fwd_hit !== 2'b01 || fwd_data[31:0] !== 32'hAB) begin miscompares++; $display("FAIL t2_bypass: got hit=%b data=%h expected 01/ab", fwd_hit, fwd_data[31:0]); end
        vectors++; if (stall_cnt !== 2'd1) begin miscompares++; $display("FAIL t2_cnt: got %0d expected 1", stall_cnt); end
        @(negedge clk); set_idle();
        #1;
        vectors++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd6, 32'hAB}) begin miscompares++; $display("FAIL t2_wb: got v=%b a=%0d d=%h expected 1/6/ab", wb_valid, wb_addr, wb_data); end
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); set_idle(); issue(5'd7, 1'b0, 32'h1);
        @(negedge clk); set_idle(); issue(5'd7, 1'b0, 32'h2);
        @(negedge clk); set_idle(); src_used = 2'b11; src_addr = {5'd7, 5'd7};
        #1;
        vectors++; if (fwd_hit !== 2'b11 || fwd_data !== {32'h2, 32'h2}) begin miscompares++; $display("FAIL t3_youngest: got hit=%b data=%h expected 11/0000000200000002", fwd_hit, fwd_data); end
        @(negedge clk); set_idle();
        #1;
        vectors++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd7, 32'h1}) begin miscompares++; $display("FAIL t3_wb_first: got v=%b a=%0d d=%h expected 1/7/1", wb_valid, wb_addr, wb_data); end
        @(negedge clk); set_idle();
        #1;
        vectors++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd7, 32'h2}) begin miscompares++; $display("FAIL t3_wb_second: got v=%b a=%0d d=%h expected 1/7/2", wb_valid, wb_addr, wb_data); end
        idle_cycles(3);
    endtask

    task automatic test_mem_wait();
        logic [CNT_W-1:0] exp_cnt;
        @(negedge clk); set_idle(); issue(5'd8, 1'b1, 32'h0);
        @(negedge clk); set_idle(); issue(5'd10, 1'b0, 32'h55);
        @(negedge clk); set_idle();
        // Three held cycles; the issued x9 must never be captured.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); set_idle(); issue(5'd9, 1'b0, 32'h99);
            src_used = 2'b11;
            src_addr = (n == 2) ? {5'd8, 5'd10} : {5'd9, 5'd10};
            #1;
            exp_cnt = CNT_W'(n + 1);
            vectors++; if ({stall, stall_reason} !== ((n == 2) ? 3'b111 : 3'b110)) begin miscompares++; $display("FAIL t4_hold%0d_stall: got %b expected %b", n, {stall, stall_reason}, (n == 2) ? 3'b111 : 3'b110); end
            vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL t4_hold%0d_wb: got %b expected 0", n, wb_valid); end
            vectors++; if (fwd_hit !== 2'b01 || fwd_data[31:0] !== 32'h55) begin miscompares++; $display("FAIL t4_hold%0d_frozen: got hit=%b data=%h expected 01/55", n, fwd_hit, fwd_data[31:0]); end
            vectors++; if (stall_cnt !== exp_cnt) begin miscompares++; $display("FAIL t4_hold%0d_cnt: got %0d expected %0d", n, stall_cnt, exp_cnt); end
        end
        @(negedge clk); set_idle(); mem_valid = 1'b1; mem_rdata = 32'hCAFE;
        src_used = 2'b11; src_addr = {5'd8, 5'd10};
        #1;
        vectors++; if ({stall, stall_reason} !== 3'b000) begin miscompares++; $display("FAIL t4_release: got %b expected 000", {stall, stall_reason}); end
        vectors++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd8, 32'hCAFE}) begin miscompares++; $display("FAIL t4_wb_load: got v=%b a=%0d d=%h expected 1/8/cafe", wb_valid, wb_addr, wb_data); end
        vectors++; if (fwd_hit !== 2'b11 || fwd_data !== {32'hCAFE, 32'h55}) begin miscompares++; $display("FAIL t4_fill_fwd: got hit=%b data=%h expected 11/0000cafe00000055", fwd_hit, fwd_data); end
        // 1 from the load-use test plus 3 held cycles saturates a 2-bit counter at 3.
        vectors++; if (stall_cnt !== 2'd3) begin miscompares++; $display("FAIL t4_cnt_sat: got %0d expected 3", stall_cnt); end
        @(negedge clk); set_idle(); src_used = 2'b10; src_addr = {5'd9, 5'd0};
        #1;
        vectors++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 5'd10, 32'h55}) begin miscompares++; $display("FAIL t4_wb_alu: got v=%b a=%0d d=%h expected 1/10/55", wb_valid, wb_addr, wb_data); end
        vectors++; if (fwd_hit !== 2'b00) begin miscompares++; $display("FAIL t4_no_x9: got %b expected 00", fwd_hit); end
        vectors++; if (stall_cnt !== 2'd3) begin miscompares++; $display("FAIL t4_cnt_hold: got %0d expected 3", stall_cnt); end
        idle_cycles(3);
    endtask

    task automatic test_x0_flush();
        @(negedge clk); set_idle(); issue(5'd0, 1'b0, 32'h77);
        @(negedge clk); set_idle(); issue(5'd3, 1'b0, 32'h33); flush = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk); set_idle(); src_used = 2'b11; src_addr = {5'd0, 5'd3};
            #1;
            vectors++; if (fwd_hit !== 2'b00 || fwd_data !== '0 || stall !== 1'b0) begin miscompares++; $display("FAIL t5_nomatch%0d: got hit=%b data=%h stall=%b expected 0/0/0", n, fwd_hit, fwd_data, stall); end
            vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL t5_noretire%0d: got %b expected 0", n, wb_valid); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); set_idle(); issue(5'd11, 1'b1, 32'h0);
        @(negedge clk); set_idle(); issue(5'd12, 1'b0, 32'h1);
        @(negedge clk); set_idle(); issue(5'd13, 1'b0, 32'h2);
        @(negedge clk); set_idle(); src_used = 2'b01; src_addr = {5'd0, 5'd12};
        #1;
        vectors++; if ({stall, stall_reason} !== 3'b110 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL t6_pre_stall: got %b wb=%b expected 110/0", {stall, stall_reason}, wb_valid); end
        vectors++; if (fwd_hit !== 2'b01 || fwd_data[31:0] !== 32'h1) begin miscompares++; $display("FAIL t6_pre_fwd: got hit=%b data=%h expected 01/1", fwd_hit, fwd_data[31:0]); end
        @(negedge clk); set_idle(); src_used = 2'b01; src_addr = {5'd0, 5'd12};
        #2 rst = 1'b1;
        #1;
        vectors++; if ({stall, stall_reason} !== 3'b000 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL t6_rst_stall: got %b wb=%b expected 000/0", {stall, stall_reason}, wb_valid); end
        vectors++; if (stall_cnt !== 2'd0) begin miscompares++; $display("FAIL t6_rst_cnt: got %0d expected 0", stall_cnt); end
        vectors++; if (fwd_hit !== 2'b00) begin miscompares++; $display("FAIL t6_rst_fwd: got %b expected 00", fwd_hit); end
        @(negedge clk); rst = 1'b0; set_idle(); mem_valid = 1'b1; mem_rdata = 32'h99;
        #1;
        vectors++; if ({stall, wb_valid} !== 2'b00) begin miscompares++; $display("FAIL t6_stray_mem: got stall=%b wb=%b expected 0/0", stall, wb_valid); end
        @(negedge clk); set_idle(); issue(5'd4, 1'b0, 32'h44);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); set_idle(); src_used = 2'b10; src_addr = {5'd4, 5'd0};
            #1;
            vectors++; if (fwd_hit !== 2'b10 || fwd_data[63:32] !== 32'h44) begin miscompares++; $display("FAIL t6_post_fwd%0d: got hit=%b data=%h expected 10/44", n, fwd_hit, fwd_data[63:32]); end
            vectors++; if (wb_valid !== ((n == 2) ? 1'b1 : 1'b0)) begin miscompares++; $display("FAIL t6_post_wb%0d: got %b expected %b", n, wb_valid, (n == 2) ? 1'b1 : 1'b0); end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_alu_chain();
        test_load_use();
        test_back_to_back();
        test_mem_wait();
        test_x0_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
